// File: rtl/vga_defs_pkg.sv
//------------------------------------------------------------------------------
// Module      : vga_defs (package)
// Description : VGA timing defaults, sprite geometry and the position clamp helper.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_defs;

    localparam int c_POS_W          = 10;
    localparam int c_H_VISIBLE_AREA = 640;
    localparam int c_H_FRONT_PORCH  = 16;
    localparam int c_H_SYNC_PULSE   = 96;
    localparam int c_H_BACK_PORCH   = 48;
    localparam int c_V_VISIBLE_AREA = 480;
    localparam int c_V_FRONT_PORCH  = 10;
    localparam int c_V_SYNC_PULSE   = 2;
    localparam int c_V_BACK_PORCH   = 33;
    localparam int c_H_TOTAL = c_H_VISIBLE_AREA + c_H_FRONT_PORCH + c_H_SYNC_PULSE + c_H_BACK_PORCH;
    localparam int c_V_TOTAL = c_V_VISIBLE_AREA + c_V_FRONT_PORCH + c_V_SYNC_PULSE + c_V_BACK_PORCH;
    localparam int c_TILE_SIZE      = 32;

    // Pull a tile back inside the visible area; the sum is one bit wider so X up to 1023 cannot wrap.
    function automatic logic [c_POS_W-1:0] clamp_pos(input logic [c_POS_W-1:0] pos,
                                                     input int unsigned        visible,
                                                     input int unsigned        tile);
        logic [c_POS_W:0] sum;
        sum = {1'b0, pos} + (c_POS_W+1)'(tile);
        if (sum > (c_POS_W+1)'(visible))
            return c_POS_W'(visible - tile);
        return pos;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_hit.sv
//------------------------------------------------------------------------------
// Module      : sprite_hit
// Description : Per-sprite shadow box captured at frame latch; flags pixel coverage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sprite_hit
    import vga_defs::*;
#(
    parameter int H_VISIBLE_AREA = c_H_VISIBLE_AREA,
    parameter int V_VISIBLE_AREA = c_V_VISIBLE_AREA,
    parameter int TILE_SIZE      = c_TILE_SIZE
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Latch,
    input  logic [c_POS_W-1:0] i_X,
    input  logic [c_POS_W-1:0] i_Y,
    input  logic               i_En,
    input  logic [c_POS_W-1:0] i_H_Count,
    input  logic [c_POS_W-1:0] i_V_Count,
    output logic               o_Hit
);

    localparam logic [c_POS_W:0] c_TILE = (c_POS_W+1)'(TILE_SIZE);

    logic [c_POS_W-1:0] r_x;
    logic [c_POS_W-1:0] r_y;
    logic               r_en;
    logic [c_POS_W:0]   w_h;
    logic [c_POS_W:0]   w_v;
    logic [c_POS_W:0]   w_x_end;
    logic [c_POS_W:0]   w_y_end;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_x  <= '0;
            r_y  <= '0;
            r_en <= 1'b0;
        end else if (i_Latch) begin
            r_x  <= clamp_pos(i_X, H_VISIBLE_AREA, TILE_SIZE);
            r_y  <= clamp_pos(i_Y, V_VISIBLE_AREA, TILE_SIZE);
            r_en <= i_En;
        end
    end

    assign w_h     = {1'b0, i_H_Count};
    assign w_v     = {1'b0, i_V_Count};
    assign w_x_end = {1'b0, r_x} + c_TILE;
    assign w_y_end = {1'b0, r_y} + c_TILE;

    assign o_Hit = r_en
                && (w_h >= {1'b0, r_x}) && (w_h < w_x_end)
                && (w_v >= {1'b0, r_y}) && (w_v < w_y_end);

endmodule

`default_nettype wire

// File: rtl/sprite_renderer.sv
//------------------------------------------------------------------------------
// Module      : sprite_renderer
// Description : VGA timing generator with tear-free sprite compositing and collision report.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sprite_renderer
    import vga_defs::*;
#(
    parameter int H_VISIBLE_AREA = c_H_VISIBLE_AREA,
    parameter int H_FRONT_PORCH  = c_H_FRONT_PORCH,
    parameter int H_SYNC_PULSE   = c_H_SYNC_PULSE,
    parameter int H_BACK_PORCH   = c_H_BACK_PORCH,
    parameter int V_VISIBLE_AREA = c_V_VISIBLE_AREA,
    parameter int V_FRONT_PORCH  = c_V_FRONT_PORCH,
    parameter int V_SYNC_PULSE   = c_V_SYNC_PULSE,
    parameter int V_BACK_PORCH   = c_V_BACK_PORCH,
    parameter int TILE_SIZE      = c_TILE_SIZE,
    parameter int NUM_SPRITES    = 5,
    parameter int COLOR_BITS     = 3
) (
    input  logic                                i_Clk,
    input  logic                                i_Reset,
    input  logic [c_POS_W*NUM_SPRITES-1:0]      i_Sprite_X,
    input  logic [c_POS_W*NUM_SPRITES-1:0]      i_Sprite_Y,
    input  logic [NUM_SPRITES-1:0]              i_Sprite_En,
    input  logic [3*COLOR_BITS*NUM_SPRITES-1:0] i_Sprite_Color,
    output logic                                o_VGA_HSync,
    output logic                                o_VGA_VSync,
    output logic [COLOR_BITS-1:0]               o_VGA_Red,
    output logic [COLOR_BITS-1:0]               o_VGA_Grn,
    output logic [COLOR_BITS-1:0]               o_VGA_Blu,
    output logic                                o_Frame_Done,
    output logic [NUM_SPRITES-1:0]              o_Collision
);

    localparam int c_PIX_W    = 3 * COLOR_BITS;
    localparam int c_H_TOT    = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int c_V_TOT    = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam logic [c_POS_W-1:0] c_H_LAST   = c_POS_W'(c_H_TOT - 1);
    localparam logic [c_POS_W-1:0] c_V_LAST   = c_POS_W'(c_V_TOT - 1);
    localparam logic [c_POS_W-1:0] c_V_LATCH  = c_POS_W'(V_VISIBLE_AREA - 1);
    localparam logic [c_POS_W-1:0] c_H_VIS    = c_POS_W'(H_VISIBLE_AREA);
    localparam logic [c_POS_W-1:0] c_V_VIS    = c_POS_W'(V_VISIBLE_AREA);
    localparam logic [c_POS_W-1:0] c_HS_START = c_POS_W'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam logic [c_POS_W-1:0] c_HS_END   = c_POS_W'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [c_POS_W-1:0] c_VS_START = c_POS_W'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam logic [c_POS_W-1:0] c_VS_END   = c_POS_W'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);

    logic [c_POS_W-1:0]     r_h_count;
    logic [c_POS_W-1:0]     r_v_count;
    logic                   r_hsync;
    logic                   r_vsync;
    logic [c_PIX_W-1:0]     r_rgb;
    logic                   r_frame_done;
    logic [NUM_SPRITES-1:0] r_collision;
    logic [NUM_SPRITES-1:0] r_coll_acc;
    logic [c_PIX_W-1:0]     r_color [NUM_SPRITES];

    logic                   w_latch;
    logic                   w_visible;
    logic [NUM_SPRITES-1:0] w_hit;
    logic [NUM_SPRITES-1:0] w_coll_set;
    logic [c_PIX_W-1:0]     w_pix;

    assign w_latch   = (r_h_count == c_H_LAST) && (r_v_count == c_V_LATCH);
    assign w_visible = (r_h_count < c_H_VIS) && (r_v_count < c_V_VIS);

    generate
        for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_sprite
            sprite_hit #(
                .H_VISIBLE_AREA (H_VISIBLE_AREA),
                .V_VISIBLE_AREA (V_VISIBLE_AREA),
                .TILE_SIZE      (TILE_SIZE)
            ) u_sprite_hit (
                .i_Clk     (i_Clk),
                .i_Reset   (i_Reset),
                .i_Latch   (w_latch),
                .i_X       (i_Sprite_X[c_POS_W*k +: c_POS_W]),
                .i_Y       (i_Sprite_Y[c_POS_W*k +: c_POS_W]),
                .i_En      (i_Sprite_En[k]),
                .i_H_Count (r_h_count),
                .i_V_Count (r_v_count),
                .o_Hit     (w_hit[k])
            );
        end
    endgenerate

    // Walk from the highest index down so the lowest-index hit is the one left standing.
    always_comb begin
        w_pix = '0;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (w_hit[k])
                w_pix = r_color[k];
        end
    end

    assign w_coll_set = (w_visible && w_hit[0]) ? {w_hit[NUM_SPRITES-1:1], 1'b0} : '0;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_h_count    <= '0;
            r_v_count    <= '0;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_rgb        <= '0;
            r_frame_done <= 1'b0;
            r_collision  <= '0;
            r_coll_acc   <= '0;
            for (int k = 0; k < NUM_SPRITES; k++)
                r_color[k] <= '0;
        end else begin
            if (r_h_count == c_H_LAST) begin
                r_h_count <= '0;
                r_v_count <= (r_v_count == c_V_LAST) ? '0 : r_v_count + c_POS_W'(1);
            end else begin
                r_h_count <= r_h_count + c_POS_W'(1);
            end

            r_hsync      <= !((r_h_count >= c_HS_START) && (r_h_count < c_HS_END));
            r_vsync      <= !((r_v_count >= c_VS_START) && (r_v_count < c_VS_END));
            r_rgb        <= w_visible ? w_pix : '0;
            r_frame_done <= w_latch;

            if (w_latch) begin
                r_collision <= r_coll_acc;
                r_coll_acc  <= '0;
                for (int k = 0; k < NUM_SPRITES; k++)
                    r_color[k] <= i_Sprite_Color[c_PIX_W*k +: c_PIX_W];
            end else begin
                r_coll_acc <= r_coll_acc | w_coll_set;
            end
        end
    end

    assign o_VGA_HSync  = r_hsync;
    assign o_VGA_VSync  = r_vsync;
    assign o_VGA_Red    = r_rgb[c_PIX_W-1 -: COLOR_BITS];
    assign o_VGA_Grn    = r_rgb[2*COLOR_BITS-1 -: COLOR_BITS];
    assign o_VGA_Blu    = r_rgb[COLOR_BITS-1:0];
    assign o_Frame_Done = r_frame_done;
    assign o_Collision  = r_collision;

endmodule

`default_nettype wire

// File: tb/tb_sprite_renderer.sv
//------------------------------------------------------------------------------
// Module      : tb_sprite_renderer
// Description : Randomised and directed bench for sprite_renderer on a shrunken raster.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sprite_renderer;

    localparam int HV = 48, HFP = 4, HS = 6, HBP = 6;
    localparam int VV = 32, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int T  = 8;
    localparam int NS = 5;
    localparam int CB = 3;
    localparam int PW = 3 * CB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [10*NS-1:0] sprite_x   = '0;
    logic [10*NS-1:0] sprite_y   = '0;
    logic [NS-1:0]    sprite_en  = '0;
    logic [PW*NS-1:0] sprite_col = '0;
    logic             hsync, vsync, frame_done;
    logic [CB-1:0]    red, grn, blu;
    logic [NS-1:0]    collision;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sprite_renderer #(
        .H_VISIBLE_AREA (HV), .H_FRONT_PORCH (HFP), .H_SYNC_PULSE (HS), .H_BACK_PORCH (HBP),
        .V_VISIBLE_AREA (VV), .V_FRONT_PORCH (VFP), .V_SYNC_PULSE (VS), .V_BACK_PORCH (VBP),
        .TILE_SIZE (T), .NUM_SPRITES (NS), .COLOR_BITS (CB)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Sprite_X     (sprite_x),
        .i_Sprite_Y     (sprite_y),
        .i_Sprite_En    (sprite_en),
        .i_Sprite_Color (sprite_col),
        .o_VGA_HSync    (hsync),
        .o_VGA_VSync    (vsync),
        .o_VGA_Red      (red),
        .o_VGA_Grn      (grn),
        .o_VGA_Blu      (blu),
        .o_Frame_Done   (frame_done),
        .o_Collision    (collision)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raster position, frame-latched sprite table and expected outputs.
    int      mh = 0, mv = 0, pix_h = 0, pix_v = 0;
    bit      m_valid = 0, pix_valid = 0;
    int      s_x [NS], s_y [NS], s_c [NS];
    bit      s_en [NS];
    bit      e_hs, e_vs, e_fd;
    int      e_rgb;
    bit [NS-1:0] e_coll, acc;

    function automatic bit covers(input int k, input int h, input int v);
        return s_en[k] && h >= s_x[k] && h < s_x[k] + T && v >= s_y[k] && v < s_y[k] + T;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mh = 0; mv = 0;
            e_hs = 1; e_vs = 1; e_rgb = 0; e_fd = 0; e_coll = '0; acc = '0;
            for (int k = 0; k < NS; k++) begin
                s_en[k] = 0; s_x[k] = 0; s_y[k] = 0; s_c[k] = 0;
            end
            m_valid = 1; pix_valid = 0;
        end else begin
            e_hs  = !(mh >= HV + HFP && mh < HV + HFP + HS);
            e_vs  = !(mv >= VV + VFP && mv < VV + VFP + VS);
            e_rgb = 0;
            if (mh < HV && mv < VV) begin
                for (int k = 0; k < NS; k++)
                    if (covers(k, mh, mv) && e_rgb == 0 && (k == 0 || !covers(0, mh, mv)))
                        ;
                for (int k = NS - 1; k >= 0; k--)
                    if (covers(k, mh, mv)) e_rgb = s_c[k];
                if (covers(0, mh, mv))
                    for (int k = 1; k < NS; k++)
                        if (covers(k, mh, mv)) acc[k] = 1'b1;
            end
            e_fd = (mh == HT - 1 && mv == VV - 1);
            if (e_fd) begin
                e_coll = acc;
                acc    = '0;
                for (int k = 0; k < NS; k++) begin
                    int x, y;
                    x = int'(sprite_x[10*k +: 10]);
                    y = int'(sprite_y[10*k +: 10]);
                    s_x[k]  = (x + T > HV) ? HV - T : x;
                    s_y[k]  = (y + T > VV) ? VV - T : y;
                    s_en[k] = sprite_en[k];
                    s_c[k]  = int'(sprite_col[PW*k +: PW]);
                end
            end
            pix_h = mh; pix_v = mv; pix_valid = 1;
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid)
            check("outs", 32'({hsync, vsync, red, grn, blu, frame_done, collision}),
                  32'({e_hs, e_vs, 9'(e_rgb), e_fd, e_coll}));
    end

    task automatic set_sprite(input int k, input int x, input int y, input bit en, input int c);
        sprite_x[10*k +: 10]   = 10'(x);
        sprite_y[10*k +: 10]   = 10'(y);
        sprite_en[k]           = en;
        sprite_col[PW*k +: PW] = PW'(c);
    endtask

    task automatic wait_fd();
        int n = 0;
        @(negedge clk);
        while (!frame_done && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME) check("fd_timeout", 0, 1);
    endtask

    task automatic wait_pixel(input int h, input int v);
        int n = 0;
        @(negedge clk);
        while (!(pix_valid && pix_h == h && pix_v == v) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME) check("pix_timeout", 0, 1);
    endtask

    task automatic check_pixel(input string tag, input int h, input int v, input int exp);
        wait_pixel(h, v);
        check(tag, 32'({red, grn, blu}), 32'(exp));
    endtask

    initial begin
        int hs_low, vs_low, fd_cnt, rgb_nz;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({hsync, vsync, red, grn, blu, frame_done, collision}),
              32'({1'b1, 1'b1, 9'h000, 1'b0, 5'b00000}));
        rst = 1'b0;

        // Timing over one full frame with nothing enabled.
        hs_low = 0; vs_low = 0; fd_cnt = 0; rgb_nz = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            hs_low += int'(!hsync);
            vs_low += int'(!vsync);
            fd_cnt += int'(frame_done);
            rgb_nz += int'({red, grn, blu} != 0);
        end
        check("hs_low_frame", hs_low, HS * VT);
        check("vs_low_frame", vs_low, VS * HT);
        check("fd_per_frame", fd_cnt, 1);
        check("rgb_black",    rgb_nz, 0);
        hs_low = 0;
        for (int i = 0; i < HT; i++) begin
            @(negedge clk);
            hs_low += int'(!hsync);
        end
        check("hs_low_line", hs_low, HS);

        // Priority and background.
        set_sprite(0, 10, 10, 1, 'h1FF);
        set_sprite(1, 14, 10, 1, 'h1C7);
        wait_fd();
        check_pixel("pix_bg",      9, 12, 'h000);
        check_pixel("pix_pri",    15, 12, 'h1FF);
        check_pixel("pix_second", 19, 12, 'h1C7);

        // Collision reported for one frame, then cleared.
        set_sprite(0, 20, 20, 1, 'h1FF);
        set_sprite(1, 0, 0, 0, 0);
        set_sprite(2, 24, 24, 1, 'h038);
        wait_fd();
        set_sprite(2, 40, 2, 1, 'h038);
        wait_fd();
        check("coll_hit", 32'(collision), 32'(5'b00100));
        wait_fd();
        check("coll_clear", 32'(collision), 32'(5'b00000));

        // Clamp at the bottom-right corner.
        set_sprite(0, 0, 0, 0, 0);
        set_sprite(2, 0, 0, 0, 0);
        set_sprite(1, 1000, 1000, 1, 'h1C7);
        wait_fd();
        check_pixel("clamp_above", 47, 23, 'h000);
        check_pixel("clamp_tl",    40, 24, 'h1C7);
        check_pixel("clamp_left",  39, 31, 'h000);
        check_pixel("clamp_br",    47, 31, 'h1C7);

        // Mid-frame input change is deferred to the next latch.
        set_sprite(1, 0, 0, 0, 0);
        set_sprite(2, 20, 16, 1, 'h038);
        wait_fd();
        wait_pixel(0, 10);
        set_sprite(2, 40, 16, 1, 'h038);
        check_pixel("defer_old", 20, 18, 'h038);
        check_pixel("defer_new", 40, 18, 'h000);
        wait_fd();
        check_pixel("moved_old", 20, 18, 'h000);
        check_pixel("moved_new", 40, 18, 'h038);

        // Random sprite traffic, changed at arbitrary points in the frame.
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                int k;
                k = int'($urandom_range(0, NS - 1));
                set_sprite(k,
                           ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 44)),
                           ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 28)),
                           $urandom_range(0, 3) != 0,
                           int'($urandom_range(1, 511)));
            end
        end

        // Reset mid-frame: outputs back to idle, nothing drawn until the next latch.
        for (int k = 0; k < NS; k++) set_sprite(k, 8 * k, 4 * k, 1, 'h1FF - k);
        wait_pixel(0, 20);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_outs", 32'({hsync, vsync, red, grn, blu, frame_done, collision}),
              32'({1'b1, 1'b1, 9'h000, 1'b0, 5'b00000}));
        rst = 1'b0;
        rgb_nz = 0;
        for (int i = 0; i < (VV - 1) * HT; i++) begin
            @(negedge clk);
            rgb_nz += int'({red, grn, blu} != 0);
        end
        check("midreset_black", rgb_nz, 0);
        wait_fd();
        check("midreset_coll", 32'(collision), 32'(0));
        repeat (FRAME / 2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
